// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use bubble, branch flush, Decode forwarding selects,
// memory-wait freeze with watchdog. Controls are combinational (act on the same edge); FSM and counters are registered.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic             UsesRs_D,
    input  logic             UsesRt_D,
    input  logic [4:0]       RW_E,
    input  logic             RegWrite_E,
    input  logic             MEMRd_E,
    input  logic [4:0]       RW_M,
    input  logic             RegWrite_M,
    input  logic             MEMRd_M,
    input  logic             MEMWr_M,
    input  logic [4:0]       RW_W,
    input  logic             RegWrite_W,
    input  logic             Taken_D,
    input  logic             mem_ready,
    output logic             stall,
    output logic             hold_PC,
    output logic             hold_FD,
    output logic             flush,
    output logic             freeze,
    output logic [1:0]       fwdA_D,
    output logic [1:0]       fwdB_D,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wcnt, wcnt_nxt;
    logic           memwait, timeout, frz, lu, err_set;
    logic [1:0]     fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src, input logic used,
        input logic [4:0] rw_e, input logic alu_e,
        input logic [4:0] rw_m, input logic we_m,
        input logic [4:0] rw_w, input logic we_w
    );
        logic [1:0] sel;
        sel = 2'd0;
        // src==0 excludes every RW_x==0 match at once
        if (used && src != 5'd0) begin
            if (alu_e && rw_e == src)
                sel = 2'd1;
            else if (we_m && rw_m == src)
                sel = 2'd2;
            else if (we_w && rw_w == src)
                sel = 2'd3;
        end
        return sel;
    endfunction

    always_comb begin
        memwait = (MEMRd_M | MEMWr_M) & ~mem_ready;
        timeout = (state == S_WAIT) && (wcnt == TMO);
        frz     = memwait & ~timeout;
        lu      = MEMRd_E & RegWrite_E & (RW_E != 5'd0) &
                  ((UsesRs_D & (Rs_D == RW_E)) | (UsesRt_D & (Rt_D == RW_E)));
        fwd_a   = fwd_sel(Rs_D, UsesRs_D, RW_E, RegWrite_E & ~MEMRd_E,
                          RW_M, RegWrite_M, RW_W, RegWrite_W);
        fwd_b   = fwd_sel(Rt_D, UsesRt_D, RW_E, RegWrite_E & ~MEMRd_E,
                          RW_M, RegWrite_M, RW_W, RegWrite_W);
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_RUN: begin
                if (memwait) begin
                    state_nxt = S_WAIT;
                    wcnt_nxt  = WCW'(1);
                end
            end
            S_WAIT: begin
                if (timeout || !memwait) begin
                    state_nxt = S_RUN;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt  = wcnt + WCW'(1);
                end
            end
            default: begin
                state_nxt = S_RUN;
                wcnt_nxt  = '0;
            end
        endcase
        // flag rises as the count reaches the limit, so it is visible in the abandon cycle
        err_set = frz && (wcnt_nxt == TMO);
    end

    // Outputs are forced quiet while reset is held, independent of inputs
    assign stall   = reset & lu & ~frz;
    assign hold_PC = reset & (lu | frz);
    assign hold_FD = reset & (lu | frz);
    assign flush   = reset & Taken_D & ~lu & ~frz;
    assign freeze  = reset & frz;
    assign fwdA_D  = reset ? fwd_a : 2'd0;
    assign fwdB_D  = reset ? fwd_b : 2'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RUN;
            wcnt      <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            mem_err <= mem_err | err_set;
            if ((stall | freeze) && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: hand vectors, corner sequences, and randomized traffic against a spec-level model.
module tb_pipeline_hazard_ctrl;

    localparam int TMO  = 4;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, reset;
    logic [4:0]    Rs_D, Rt_D, RW_E, RW_M, RW_W;
    logic          UsesRs_D, UsesRt_D, RegWrite_E, MEMRd_E, RegWrite_M, MEMRd_M, MEMWr_M;
    logic          RegWrite_W, Taken_D, mem_ready;
    logic          stall, hold_PC, hold_FD, flush, freeze, mem_err;
    logic [1:0]    fwdA_D, fwdB_D;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // model state: consecutive frozen cycles so far, sticky error, event counts
    int m_wait, m_scnt, m_fcnt;
    bit m_err, m_frz, m_stall, m_flush;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .UsesRs_D(UsesRs_D), .UsesRt_D(UsesRt_D),
        .RW_E(RW_E), .RegWrite_E(RegWrite_E), .MEMRd_E(MEMRd_E),
        .RW_M(RW_M), .RegWrite_M(RegWrite_M), .MEMRd_M(MEMRd_M), .MEMWr_M(MEMWr_M),
        .RW_W(RW_W), .RegWrite_W(RegWrite_W), .Taken_D(Taken_D), .mem_ready(mem_ready),
        .stall(stall), .hold_PC(hold_PC), .hold_FD(hold_FD), .flush(flush), .freeze(freeze),
        .fwdA_D(fwdA_D), .fwdB_D(fwdB_D), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [4:0] rs, rt; logic urs, urt;
        logic [4:0] rwe; logic rege, mrde;
        logic [4:0] rwm; logic regm, mrdm, mwrm;
        logic [4:0] rww; logic regw, taken, rdy;
        logic [1:0] ea, eb; logic es, eh, ef, ez;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        Rs_D = 0; Rt_D = 0; UsesRs_D = 0; UsesRt_D = 0;
        RW_E = 0; RegWrite_E = 0; MEMRd_E = 0;
        RW_M = 0; RegWrite_M = 0; MEMRd_M = 0; MEMWr_M = 0;
        RW_W = 0; RegWrite_W = 0; Taken_D = 0; mem_ready = 1;
    endtask

    function automatic int fsel(input logic [4:0] src, input logic used);
        if (!used || src == 0) return 0;
        if (RegWrite_E && !MEMRd_E && RW_E == src) return 1;
        if (RegWrite_M && RW_M == src) return 2;
        if (RegWrite_W && RW_W == src) return 3;
        return 0;
    endfunction

    task automatic model_clear();
        m_wait = 0; m_scnt = 0; m_fcnt = 0;
        m_err = 0; m_frz = 0; m_stall = 0; m_flush = 0;
    endtask

    // evaluate expectations for the current inputs and compare every output
    task automatic check_model();
        bit lu, mw;
        lu = MEMRd_E && RegWrite_E && RW_E != 0 &&
             ((UsesRs_D && Rs_D == RW_E) || (UsesRt_D && Rt_D == RW_E));
        mw = (MEMRd_M || MEMWr_M) && !mem_ready;
        m_frz   = mw && (m_wait < TMO);
        m_stall = lu && !m_frz;
        m_flush = Taken_D && !lu && !m_frz;
        chk("model.stall",   int'(stall),     int'(m_stall));
        chk("model.hold_PC", int'(hold_PC),   int'(lu || m_frz));
        chk("model.hold_FD", int'(hold_FD),   int'(lu || m_frz));
        chk("model.flush",   int'(flush),     int'(m_flush));
        chk("model.freeze",  int'(freeze),    int'(m_frz));
        chk("model.fwdA",    int'(fwdA_D),    fsel(Rs_D, UsesRs_D));
        chk("model.fwdB",    int'(fwdB_D),    fsel(Rt_D, UsesRt_D));
        chk("model.mem_err", int'(mem_err),   int'(m_err));
        chk("model.scnt",    int'(stall_cnt), m_scnt);
        chk("model.fcnt",    int'(flush_cnt), m_fcnt);
    endtask

    task automatic commit();
        @(posedge clk);
        if (m_frz) begin
            m_wait++;
            if (m_wait == TMO) m_err = 1;
        end else begin
            m_wait = 0;
        end
        if (m_stall || m_frz) m_scnt = (m_scnt == CMAX) ? CMAX : m_scnt + 1;
        if (m_flush)          m_fcnt = (m_fcnt == CMAX) ? CMAX : m_fcnt + 1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"},   int'(stall),     0);
        chk({tag, ".hold_PC"}, int'(hold_PC),   0);
        chk({tag, ".hold_FD"}, int'(hold_FD),   0);
        chk({tag, ".flush"},   int'(flush),     0);
        chk({tag, ".freeze"},  int'(freeze),    0);
        chk({tag, ".fwdA"},    int'(fwdA_D),    0);
        chk({tag, ".fwdB"},    int'(fwdB_D),    0);
        chk({tag, ".mem_err"}, int'(mem_err),   0);
        chk({tag, ".scnt"},    int'(stall_cnt), 0);
        chk({tag, ".fcnt"},    int'(flush_cnt), 0);
    endtask

    // reset with hazard-rich inputs applied, proving the outputs are gated
    task automatic do_reset();
        @(negedge clk);
        Rs_D = 5'd7; UsesRs_D = 1; RW_E = 5'd7; RegWrite_E = 1; MEMRd_E = 1;
        Taken_D = 1; MEMRd_M = 1; mem_ready = 0; Rt_D = 5'd3; UsesRt_D = 1;
        RW_W = 5'd3; RegWrite_W = 1;
        #1 reset = 0;
        #1 check_all_zero("reset");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        clear_in();
        reset = 1;
    endtask

    initial begin
        reset = 1;
        clear_in();
        model_clear();
        #2 reset = 0;
        #1 check_all_zero("por");
        @(negedge clk);
        reset = 1;

        vecs[0]  = '{5,0,1,0, 5,1,0, 5,1,0,0, 5,1, 0,1, 1,0,0,0,0,0};
        vecs[1]  = '{5,0,1,0, 5,0,0, 5,1,0,0, 5,1, 0,1, 2,0,0,0,0,0};
        vecs[2]  = '{5,0,1,0, 5,0,0, 5,0,0,0, 5,1, 0,1, 3,0,0,0,0,0};
        vecs[3]  = '{0,0,1,0, 5,1,0, 5,1,0,0, 5,1, 0,1, 0,0,0,0,0,0};
        vecs[4]  = '{0,0,1,1, 0,1,0, 0,1,0,0, 0,1, 0,1, 0,0,0,0,0,0};
        vecs[5]  = '{5,5,0,0, 5,1,0, 5,1,0,0, 5,1, 0,1, 0,0,0,0,0,0};
        vecs[6]  = '{0,7,0,1, 7,1,1, 0,0,0,0, 0,0, 0,1, 0,0,1,1,0,0};
        vecs[7]  = '{0,7,0,1, 7,1,1, 0,0,0,0, 0,0, 1,1, 0,0,1,1,0,0};
        vecs[8]  = '{0,0,0,0, 0,0,0, 0,0,0,0, 0,0, 1,1, 0,0,0,0,1,0};
        vecs[9]  = '{0,0,0,1, 0,1,1, 0,0,0,0, 0,0, 1,1, 0,0,0,0,1,0};
        vecs[10] = '{9,0,1,0, 0,0,0, 9,1,0,1, 0,0, 0,1, 2,0,0,0,0,0};
        vecs[11] = '{3,3,1,1, 3,1,0, 3,1,0,0, 3,1, 0,1, 1,1,0,0,0,0};
        vecs[12] = '{4,0,1,0, 4,1,1, 4,1,0,0, 0,0, 0,1, 2,0,1,1,0,0};
        vecs[13] = '{4,0,1,0, 4,0,1, 0,0,0,0, 4,1, 0,1, 3,0,0,0,0,0};

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            Rs_D = vecs[i].rs; Rt_D = vecs[i].rt; UsesRs_D = vecs[i].urs; UsesRt_D = vecs[i].urt;
            RW_E = vecs[i].rwe; RegWrite_E = vecs[i].rege; MEMRd_E = vecs[i].mrde;
            RW_M = vecs[i].rwm; RegWrite_M = vecs[i].regm; MEMRd_M = vecs[i].mrdm; MEMWr_M = vecs[i].mwrm;
            RW_W = vecs[i].rww; RegWrite_W = vecs[i].regw; Taken_D = vecs[i].taken; mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d.fwdA", i),   int'(fwdA_D),  int'(vecs[i].ea));
            chk($sformatf("vec%0d.fwdB", i),   int'(fwdB_D),  int'(vecs[i].eb));
            chk($sformatf("vec%0d.stall", i),  int'(stall),   int'(vecs[i].es));
            chk($sformatf("vec%0d.hold", i),   int'(hold_PC & hold_FD), int'(vecs[i].eh));
            chk($sformatf("vec%0d.flush", i),  int'(flush),   int'(vecs[i].ef));
            chk($sformatf("vec%0d.freeze", i), int'(freeze),  int'(vecs[i].ez));
            check_model();
            commit();
        end

        // load-use: one bubble, then forward from Memory
        do_reset();
        @(negedge clk);
        MEMRd_E = 1; RegWrite_E = 1; RW_E = 7; Rt_D = 7; UsesRt_D = 1;
        #1 chk("lu.stall", int'(stall), 1); chk("lu.hold", int'(hold_PC & hold_FD), 1);
        check_model(); commit();
        @(negedge clk);
        MEMRd_E = 0; RegWrite_E = 0; RW_E = 0;
        MEMRd_M = 1; RegWrite_M = 1; RW_M = 7; mem_ready = 1;
        #1 chk("lu2.stall", int'(stall), 0); chk("lu2.fwdB", int'(fwdB_D), 2);
        chk("lu2.scnt", int'(stall_cnt), 1);
        check_model(); commit();

        // branch depending on a load
        do_reset();
        @(negedge clk);
        MEMRd_E = 1; RegWrite_E = 1; RW_E = 7; Rt_D = 7; UsesRt_D = 1; Taken_D = 1;
        #1 chk("br.flush0", int'(flush), 0); chk("br.stall", int'(stall), 1);
        check_model(); commit();
        @(negedge clk);
        MEMRd_E = 0; RegWrite_E = 0; RW_E = 0;
        MEMRd_M = 1; RegWrite_M = 1; RW_M = 7; mem_ready = 1;
        #1 chk("br.flush1", int'(flush), 1);
        check_model(); commit();
        @(negedge clk);
        clear_in();
        #1 chk("br.fcnt", int'(flush_cnt), 1);
        check_model(); commit();

        // memory wait of three cycles overriding load-use and branch
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            MEMRd_M = 1; mem_ready = (c == 3);
            Taken_D = (c < 3); MEMRd_E = (c < 3); RegWrite_E = 1; RW_E = 6; Rs_D = 6; UsesRs_D = 1;
            #1 chk($sformatf("mw%0d.freeze", c), int'(freeze), (c < 3) ? 1 : 0);
            if (c < 3) begin
                chk($sformatf("mw%0d.stall", c), int'(stall), 0);
                chk($sformatf("mw%0d.flush", c), int'(flush), 0);
            end
            check_model(); commit();
        end
        @(negedge clk);
        clear_in();
        #1 chk("mw.scnt", int'(stall_cnt), 3);
        check_model(); commit();

        // watchdog: four frozen cycles, then abandon with error
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            MEMRd_M = 1; mem_ready = 0;
            #1 chk($sformatf("wd%0d.freeze", c), int'(freeze), (c < 4) ? 1 : 0);
            chk($sformatf("wd%0d.err", c), int'(mem_err), (c < 4) ? 0 : 1);
            check_model(); commit();
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_in();
            #1 chk("wd.err_sticky", int'(mem_err), 1);
            check_model(); commit();
        end

        // asynchronous reset between edges in the middle of a wait
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            MEMRd_M = 1; mem_ready = 0; Taken_D = 1; Rs_D = 2; UsesRs_D = 1; RW_W = 2; RegWrite_W = 1;
            #1 check_model(); commit();
        end
        #2 reset = 0;
        #1 check_all_zero("async");
        model_clear();
        #1 reset = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            MEMRd_M = 1; mem_ready = 0; Taken_D = 0;
            #1 if (c == 3) chk("async.run_freeze", int'(freeze), 1);
            check_model(); commit();
        end

        // randomized traffic against the model, alternating memory-latency regimes
        do_reset();
        for (int blk = 0; blk < 10; blk++) begin
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                Rs_D = 5'($urandom_range(0, 3)); Rt_D = 5'($urandom_range(0, 3));
                UsesRs_D = 1'($urandom); UsesRt_D = 1'($urandom);
                RW_E = 5'($urandom_range(0, 3)); RegWrite_E = 1'($urandom); MEMRd_E = 1'($urandom);
                RW_M = 5'($urandom_range(0, 3)); RegWrite_M = 1'($urandom);
                MEMRd_M = 1'($urandom); MEMWr_M = 1'($urandom);
                RW_W = 5'($urandom_range(0, 3)); RegWrite_W = 1'($urandom);
                Taken_D = 1'($urandom);
                mem_ready = ($urandom_range(0, 9) >= ((blk % 2) ? 9 : 3));
                #1 check_model();
                commit();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and pipeline-sequencing controller for the 5-stage predicated RISC core. It watches the register operands in Decode and the destinations in Execute, Memory and Writeback. From these it generates the load-use bubble (`stall`) into the Decode-to-Execute register, the hold and flush controls for PC and Fetch-to-Decode, Decode-stage forwarding selects, and a global freeze while a multi-cycle data-memory access is outstanding. It also keeps a memory-wait watchdog and saturating stall/flush performance counters.

## Interface
- `MEM_TIMEOUT`, default 255: maximum consecutive wait cycles before watchdog error (1..65535).
- `CNT_W`, default 16: width of performance counters.

- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-low reset.
- `Rs_D`, `Rt_D`  in  5 each  source register numbers of the instruction in Decode.
- `UsesRs_D`, `UsesRt_D`  in  1 each  Decode instruction actually reads Rs/Rt.
- `RW_E`, `RegWrite_E`, `MEMRd_E`  in  5/1/1  Execute destination, write enable, load flag.
- `RW_M`, `RegWrite_M`, `MEMRd_M`, `MEMWr_M`  in  5/1/1/1  Memory-stage equivalents plus store flag.
- `RW_W`, `RegWrite_W`  in  5/1  Writeback destination and write enable.
- `Taken_D`  in  1  control-flow redirect resolved in Decode.
- `mem_ready`  in  1  data memory completes the current access this cycle.
- `stall`  out  1  insert bubble into Decode-to-Execute register.
- `hold_PC`, `hold_FD`  out  1 each  PC and Fetch-to-Decode keep their value.
- `flush`  out  1  clear Fetch-to-Decode.
- `freeze`  out  1  all pipeline registers hold, including Decode-to-Execute, Execute-to-Memory and Memory-to-Writeback.
- `fwdA_D`, `fwdB_D`  out  2 each  Decode operand source: 0 register file, 1 Execute ALU result, 2 Memory result/load data, 3 Writeback data.
- `mem_err`  out  1  sticky watchdog timeout flag.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  saturating event counters.

## Operation
- **Register 0 rule.** Register 0 is never a hazard or forwarding source; any match against `RW_x==0` is ignored.
- **Forwarding.** For each used source, the priority is Execute > Memory > Writeback > register file.
  - Execute is selected only if `RegWrite_E & ~MEMRd_E` and `RW_E` matches.
  - Memory is selected if `RegWrite_M` and `RW_M` matches.
  - Writeback is selected if `RegWrite_W` and `RW_W` matches.
  - If the source is unused, its select is 0.
- **Load-use.** `lu = MEMRd_E & RegWrite_E & (RW_E!=0) & ((UsesRs_D & Rs_D==RW_E) | (UsesRt_D & Rt_D==RW_E))`. When `lu` is set, `stall`, `hold_PC` and `hold_FD` are asserted. This always costs exactly one bubble, because the next cycle forwards from Memory.
- **Control flow.** `flush = Taken_D & ~lu & ~freeze`. A branch that depends on a pending load waits for the load and redirects only after it re-resolves. Flush never touches Decode-to-Execute.
- **Memory wait (`memwait`).** `memwait = (MEMRd_M | MEMWr_M) & ~mem_ready`.
  - `memwait` forces `freeze=1` and `hold_PC=hold_FD=1`.
  - It overrides `lu` and `Taken_D`, so `stall=0` and `flush=0` while frozen.
- **FSM states.**
  - **RUN:** go to WAIT when `memwait`; the wait counter loads 1.
  - **WAIT:** the counter increments each cycle `memwait` stays high.
    - `mem_ready=1` returns to RUN with the counter cleared.
    - Counter reaching `MEM_TIMEOUT` sets `mem_err`, forces `freeze=0` for that cycle (the access is abandoned) and returns to RUN. The counter only has to hold values up to `MEM_TIMEOUT`.
- **`mem_err`** stays set until reset.
- **Counters.** `stall_cnt` increments on every cycle with `stall=1` or `freeze=1`. `flush_cnt` increments on every cycle with `flush=1`. Both saturate at all-ones.

## Timing
- `stall`, `hold_*`, `flush`, `freeze` and `fwd*` are combinational from current inputs and FSM state. They act on the same rising edge.
- Wait counter, state, `mem_err` and counters are registered and update on the rising `clk` edge.
- **Reset** (`reset=0`, asynchronous):
  - state RUN, wait counter 0, `mem_err=0`, `stall_cnt=flush_cnt=0`;
  - all control outputs 0 and `fwd*=0`, regardless of inputs, while reset is low.
- **Reset mid-WAIT** aborts the wait immediately. Counters are lost.
- **Timeout boundary.** With `MEM_TIMEOUT=N`, freeze is high for N cycles. Cycle N+1 has `freeze=0` and `mem_err=1`.

## Test plan
- **Forwarding priority.** `Rs_D=5`, `UsesRs_D=1`, and `RW_E=RW_M=RW_W=5` with all write enables set and `MEMRd_E=0` -> `fwdA_D=1`. Drop `RegWrite_E` -> 2. Drop `RegWrite_M` -> 3. Set `Rs_D=0` -> 0.
- **Load-use.** `MEMRd_E=1`, `RegWrite_E=1`, `RW_E=7`, `Rt_D=7`, `UsesRt_D=1` -> one cycle with `stall=hold_PC=hold_FD=1`. The next cycle has the load in Memory, `fwdB_D=2`, and `stall_cnt=1`.
- **Branch on load.** Load-use condition plus `Taken_D=1` -> `flush=0` in the stall cycle and `flush=1` the next cycle. `flush_cnt` ends at 1.
- **Memory wait.** `MEMRd_M=1` with `mem_ready` low for 3 cycles -> `freeze=1` for 3 cycles, `stall=0` and `flush=0` even with `Taken_D=1`. Release on the 4th cycle; `stall_cnt=3`.
- **Watchdog.** `MEM_TIMEOUT=4` with `mem_ready` stuck low -> 4 frozen cycles, then `freeze=0` and `mem_err=1`. `mem_err` stays set until reset.
- **Async reset.** Pulse `reset` low mid-WAIT between clock edges -> all outputs 0 immediately, and state is RUN after release.
